// File: rtl/vx_mem_perf_collector.sv
// Memory performance collector: counts accepted reads and writes on the
// LLC-to-memory ports and accumulates read latency as the sum over cycles
// of in-flight reads. All outputs are registered.
module vx_mem_perf_collector #(
    parameter int NUM_PORTS   = 1,
    parameter int CTR_WIDTH   = 44,
    parameter int MAX_PENDING = 64,
    localparam int PW  = $clog2(NUM_PORTS * MAX_PENDING + 1),
    localparam int PPW = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 perf_en,
    input  logic                 perf_clr,
    input  logic [NUM_PORTS-1:0] mem_req_valid,
    input  logic [NUM_PORTS-1:0] mem_req_ready,
    input  logic [NUM_PORTS-1:0] mem_req_rw,
    input  logic [NUM_PORTS-1:0] mem_rsp_valid,
    input  logic [NUM_PORTS-1:0] mem_rsp_ready,
    output logic [CTR_WIDTH-1:0] perf_reads,
    output logic [CTR_WIDTH-1:0] perf_writes,
    output logic [CTR_WIDTH-1:0] perf_latency,
    output logic [PW-1:0]        pending_reads,
    output logic                 underflow_err
);

    logic [NUM_PORTS-1:0] rd_fire;
    logic [NUM_PORTS-1:0] wr_fire;
    logic [NUM_PORTS-1:0] rsp_fire;

    logic [PPW-1:0]       pend_q   [NUM_PORTS];
    logic [PPW-1:0]       pend_nxt [NUM_PORTS];
    logic [PW-1:0]        pend_sum;
    logic [CTR_WIDTH-1:0] rd_cnt;
    logic [CTR_WIDTH-1:0] wr_cnt;
    logic                 uf_any;
    logic                 sat_any;

    assign rd_fire  = mem_req_valid & mem_req_ready & ~mem_req_rw;
    assign wr_fire  = mem_req_valid & mem_req_ready &  mem_req_rw;
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

    // Next pending count per port, event popcounts and anomaly detection.
    // The pending sum uses next-state values so pending_reads tracks the
    // per-port counters with no extra cycle of lag.
    always_comb begin
        uf_any   = 1'b0;
        sat_any  = 1'b0;
        pend_sum = '0;
        rd_cnt   = '0;
        wr_cnt   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pend_nxt[p] = pend_q[p];
            if (rd_fire[p] && !rsp_fire[p]) begin
                if (pend_q[p] == PPW'(MAX_PENDING)) begin
                    sat_any = 1'b1;
                end else begin
                    pend_nxt[p] = pend_q[p] + PPW'(1);
                end
            end else if (!rd_fire[p] && rsp_fire[p]) begin
                if (pend_q[p] == '0) begin
                    uf_any = 1'b1;
                end else begin
                    pend_nxt[p] = pend_q[p] - PPW'(1);
                end
            end
            pend_sum = pend_sum + PW'(pend_nxt[p]);
            rd_cnt   = rd_cnt + CTR_WIDTH'(rd_fire[p]);
            wr_cnt   = wr_cnt + CTR_WIDTH'(wr_fire[p]);
        end
    end

    // Pending tracking follows real traffic; perf_en and perf_clr do not touch it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pend_q[p] <= '0;
            end
            pending_reads <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pend_q[p] <= pend_nxt[p];
            end
            pending_reads <= pend_sum;
        end
    end

    // Performance counters; clear wins over enable, additions wrap silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_reads   <= '0;
            perf_writes  <= '0;
            perf_latency <= '0;
        end else if (perf_clr) begin
            perf_reads   <= '0;
            perf_writes  <= '0;
            perf_latency <= '0;
        end else if (perf_en) begin
            perf_reads   <= perf_reads + rd_cnt;
            perf_writes  <= perf_writes + wr_cnt;
            perf_latency <= perf_latency + CTR_WIDTH'(pending_reads);
        end
    end

    // Sticky flag for a response arriving with nothing outstanding on its port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underflow_err <= 1'b0;
        end else if (perf_clr) begin
            underflow_err <= 1'b0;
        end else if (uf_any) begin
            underflow_err <= 1'b1;
        end
    end

    // A read accepted while a port is already at its in-flight limit is lost
    // from the pending count; flag it loudly in simulation.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!sat_any) else $error("vx_mem_perf_collector: pending read counter saturated");
        end
    end

endmodule

// File: tb/tb_vx_mem_perf_collector.sv
// Directed self-checking bench for vx_mem_perf_collector: a 4-port instance
// for the main traffic scenarios and a 1-port, 4-bit-counter instance to
// exercise counter wrap-around.
module tb_vx_mem_perf_collector;

    logic clk = 1'b0;
    logic reset_n;

    // 4-port instance
    logic        perf_en, perf_clr;
    logic [3:0]  req_valid, req_ready, req_rw, rsp_valid, rsp_ready;
    logic [43:0] perf_reads, perf_writes, perf_latency;
    logic [8:0]  pending_reads;
    logic        underflow_err;

    // 1-port, narrow-counter instance
    logic        w_en, w_clr;
    logic        w_req_valid, w_req_ready, w_req_rw, w_rsp_valid, w_rsp_ready;
    logic [3:0]  w_reads, w_writes, w_latency;
    logic [6:0]  w_pending;
    logic        w_uf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vx_mem_perf_collector #(.NUM_PORTS(4), .CTR_WIDTH(44), .MAX_PENDING(64)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .perf_en       (perf_en),
        .perf_clr      (perf_clr),
        .mem_req_valid (req_valid),
        .mem_req_ready (req_ready),
        .mem_req_rw    (req_rw),
        .mem_rsp_valid (rsp_valid),
        .mem_rsp_ready (rsp_ready),
        .perf_reads    (perf_reads),
        .perf_writes   (perf_writes),
        .perf_latency  (perf_latency),
        .pending_reads (pending_reads),
        .underflow_err (underflow_err)
    );

    vx_mem_perf_collector #(.NUM_PORTS(1), .CTR_WIDTH(4), .MAX_PENDING(64)) dut_w (
        .clk           (clk),
        .reset_n       (reset_n),
        .perf_en       (w_en),
        .perf_clr      (w_clr),
        .mem_req_valid (w_req_valid),
        .mem_req_ready (w_req_ready),
        .mem_req_rw    (w_req_rw),
        .mem_rsp_valid (w_rsp_valid),
        .mem_rsp_ready (w_rsp_ready),
        .perf_reads    (w_reads),
        .perf_writes   (w_writes),
        .perf_latency  (w_latency),
        .pending_reads (w_pending),
        .underflow_err (w_uf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        perf_en   = 1'b0;
        perf_clr  = 1'b0;
        req_valid = 4'h0;
        req_ready = 4'hF;
        req_rw    = 4'h0;
        rsp_valid = 4'h0;
        rsp_ready = 4'hF;
        w_en        = 1'b0;
        w_clr       = 1'b0;
        w_req_valid = 1'b0;
        w_req_ready = 1'b1;
        w_req_rw    = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_reads",   64'(perf_reads),    64'd0);
        chk("rst_writes",  64'(perf_writes),   64'd0);
        chk("rst_latency", 64'(perf_latency),  64'd0);
        chk("rst_pending", 64'(pending_reads), 64'd0);
        chk("rst_uf",      64'(underflow_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Narrow instance: build 5 pending with counting off, then wrap latency
        w_req_valid = 1'b1;
        repeat (5) tick();
        w_req_valid = 1'b0;
        chk("w_pending5", 64'(w_pending), 64'd5);
        chk("w_reads_off", 64'(w_reads), 64'd0);
        w_en = 1'b1;
        repeat (3) tick();
        chk("w_lat_15", 64'(w_latency), 64'd15);
        tick();
        chk("w_lat_wrap", 64'(w_latency), 64'd4);
        w_en = 1'b0;

        // Single read on port 0, response five cycles later
        perf_en = 1'b1;
        req_valid = 4'b0001;
        tick();
        req_valid = 4'h0;
        chk("rd1_reads",   64'(perf_reads),    64'd1);
        chk("rd1_pending", 64'(pending_reads), 64'd1);
        chk("rd1_lat0",    64'(perf_latency),  64'd0);
        repeat (4) tick();
        chk("rd1_lat4",    64'(perf_latency),  64'd4);
        rsp_valid = 4'b0001;
        tick();
        rsp_valid = 4'h0;
        chk("rd1_lat5",    64'(perf_latency),  64'd5);
        chk("rd1_pend0",   64'(pending_reads), 64'd0);
        chk("rd1_uf",      64'(underflow_err), 64'd0);

        // All ports read for 3 cycles, then port 3 writes for 2 cycles
        req_valid = 4'hF;
        req_rw    = 4'h0;
        repeat (3) tick();
        req_valid = 4'b1000;
        req_rw    = 4'b1000;
        repeat (2) tick();
        req_valid = 4'h0;
        req_rw    = 4'h0;
        chk("burst_reads",   64'(perf_reads),    64'd13);
        chk("burst_writes",  64'(perf_writes),   64'd2);
        chk("burst_pending", 64'(pending_reads), 64'd12);
        chk("burst_lat",     64'(perf_latency),  64'd41);

        // Port 0 down to 2 pending, then read and response together
        rsp_valid = 4'b0001;
        tick();
        rsp_valid = 4'h0;
        chk("drain_pending", 64'(pending_reads), 64'd11);
        chk("drain_lat",     64'(perf_latency),  64'd53);
        req_valid = 4'b0001;
        rsp_valid = 4'b0001;
        tick();
        req_valid = 4'h0;
        rsp_valid = 4'h0;
        chk("same_pending", 64'(pending_reads), 64'd11);
        chk("same_reads",   64'(perf_reads),    64'd14);
        chk("same_lat",     64'(perf_latency),  64'd64);

        // Clear with enable and 4 reads in the same cycle
        perf_clr  = 1'b1;
        req_valid = 4'hF;
        tick();
        perf_clr  = 1'b0;
        req_valid = 4'h0;
        chk("clr_reads",   64'(perf_reads),    64'd0);
        chk("clr_writes",  64'(perf_writes),   64'd0);
        chk("clr_lat",     64'(perf_latency),  64'd0);
        chk("clr_pending", 64'(pending_reads), 64'd15);

        // Counting disabled for 10 cycles; pending still follows traffic
        perf_en   = 1'b0;
        req_valid = 4'b0100;
        tick();
        req_valid = 4'h0;
        repeat (9) tick();
        chk("frz_reads",   64'(perf_reads),    64'd0);
        chk("frz_writes",  64'(perf_writes),   64'd0);
        chk("frz_lat",     64'(perf_latency),  64'd0);
        chk("frz_pending", 64'(pending_reads), 64'd16);

        // Port 3 holds 4 reads; the fifth response underflows
        rsp_valid = 4'b1000;
        repeat (4) tick();
        chk("uf_pend12", 64'(pending_reads), 64'd12);
        chk("uf_not_yet", 64'(underflow_err), 64'd0);
        tick();
        rsp_valid = 4'h0;
        chk("uf_pend_hold", 64'(pending_reads), 64'd12);
        chk("uf_set",       64'(underflow_err), 64'd1);
        repeat (3) tick();
        chk("uf_sticky",    64'(underflow_err), 64'd1);
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("uf_cleared",   64'(underflow_err), 64'd0);
        chk("uf_clr_pend",  64'(pending_reads), 64'd12);

        // Reset mid-burst takes effect without a clock edge
        perf_en   = 1'b1;
        req_valid = 4'hF;
        repeat (2) tick();
        chk("mid_reads",   64'(perf_reads),    64'd8);
        chk("mid_lat",     64'(perf_latency),  64'd28);
        chk("mid_pending", 64'(pending_reads), 64'd20);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_reads",   64'(perf_reads),    64'd0);
        chk("arst_writes",  64'(perf_writes),   64'd0);
        chk("arst_lat",     64'(perf_latency),  64'd0);
        chk("arst_pending", 64'(pending_reads), 64'd0);
        chk("arst_uf",      64'(underflow_err), 64'd0);
        chk("arst_w_pend",  64'(w_pending),     64'd0);
        req_valid = 4'h0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_rst_pend", 64'(pending_reads), 64'd0);

        // Stale response after reset flags underflow
        rsp_valid = 4'b0010;
        tick();
        rsp_valid = 4'h0;
        chk("stale_uf",   64'(underflow_err), 64'd1);
        chk("stale_pend", 64'(pending_reads), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vx_mem_perf_collector.md
Name: VX_mem_perf_collector

Overview:
Producer of the `mem` field of the memory performance interface. It watches the handshakes between the last-level cache and the memory bus on NUM_PORTS ports and accumulates three counters: read requests, write requests and read latency. Read latency is the sum over cycles of in-flight reads. Its outputs are registered and feed the mem_perf_t fields (reads, writes, latency) directly.

Parameters:
NUM_PORTS, 1, number of memory bus ports observed (1..8)
CTR_WIDTH, 44, counter width; equals `PERF_CTR_BITS
MAX_PENDING, 64, maximum in-flight reads per port; sets pending counter width PW = clog2(NUM_PORTS*MAX_PENDING+1)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
perf_en  in  1  counting enable; pending tracking ignores it
perf_clr  in  1  synchronous clear of counters and error flag
mem_req_valid  in  NUM_PORTS  request valid per port
mem_req_ready  in  NUM_PORTS  request ready per port
mem_req_rw  in  NUM_PORTS  1 = write, 0 = read
mem_rsp_valid  in  NUM_PORTS  response valid per port
mem_rsp_ready  in  NUM_PORTS  response ready per port
perf_reads  out  CTR_WIDTH  accepted read requests
perf_writes  out  CTR_WIDTH  accepted write requests
perf_latency  out  CTR_WIDTH  accumulated read-pending cycles
pending_reads  out  PW  current total in-flight reads
underflow_err  out  1  sticky: a response fired with zero pending reads on that port

Behaviour:
- Reset (reset_n low, asynchronous): all outputs and internal per-port pending counters go to 0. They stay 0 while reset_n is low. Counting starts on the first rising edge after deassertion.
- Events, per port p:
  - req_fire[p] = valid & ready.
  - rd_fire = req_fire & ~rw; wr_fire = req_fire & rw.
  - rsp_fire[p] = rsp_valid & rsp_ready.
  - Writes never produce responses.
- Per-port pending counter, registered, updated regardless of perf_en:
  - +1 on rd_fire only; -1 on rsp_fire only; unchanged when both fire in the same cycle.
  - rsp_fire at pending 0 with no rd_fire: counter holds 0 and underflow_err sets.
  - At MAX_PENDING, a rd_fire without rsp_fire holds the value (saturates). This is a simulation assertion failure.
- pending_reads = registered sum of the per-port counters (one-cycle latency).
- Counters, when perf_en=1:
  - perf_reads += popcount(rd_fire).
  - perf_writes += popcount(wr_fire).
  - perf_latency += pending_reads register value at the start of the cycle. The cycle in which a read is accepted does not add; the cycle in which its response fires does add.
- Output latency: an event in cycle N is visible on the outputs at N+1.
- Arithmetic: all counter additions are modulo 2^CTR_WIDTH and wrap silently. popcount is zero-extended.
- perf_clr=1: the next edge zeroes perf_reads, perf_writes, perf_latency and underflow_err; events in that cycle are discarded. Pending counters are NOT cleared, because they track real in-flight traffic. perf_clr has priority over perf_en.
- perf_en=0: the three counters hold; pending tracking and underflow_err continue.
- Reset mid-traffic: pending counters drop to 0. Responses arriving after reset set underflow_err; this is expected and documented.
- No combinational path from inputs to outputs.

Test Plan:
- Reset release, then one read on port 0 at cycle 2 and its response at cycle 7 -> perf_reads=1 at cycle 3, pending_reads=1 during cycles 3..7, perf_latency=5 at cycle 8, pending_reads=0 at cycle 8.
- NUM_PORTS=4, all ports fire reads for 3 cycles, plus port 3 fires writes for 2 cycles -> perf_reads=12, perf_writes=2, pending_reads=12.
- Same-cycle rd_fire and rsp_fire on a port with pending=2 -> pending stays 2, perf_reads increments by 1.
- Preload perf_latency to 2^44-3 by forcing, then 5 pending for one cycle -> perf_latency wraps to 2.
- perf_clr asserted together with perf_en=1 and 4 rd_fires -> counters all 0 next cycle, pending_reads=4; perf_en=0 for 10 cycles -> counters frozen.
- rsp_fire with no pending read -> underflow_err=1 and stays set until perf_clr; assert reset_n low mid-burst -> all outputs 0 immediately, without waiting for a clock edge.
